// File: rtl/prim_xoshiro256pp_ctrl.sv
// Seed, step and buffer controller for a prim_xoshiro256pp instance.
// Define PRIM_XOSHIRO_CTRL_BYPASS_EN for a same-cycle bypass of an empty FIFO.
module prim_xoshiro256pp_ctrl #(
  parameter int unsigned OutputDw       = 64,
  parameter int unsigned SeedChunkW     = 32,
  parameter int unsigned ReseedInterval = 1024,
  parameter int unsigned FifoDepth      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  reseed_req_i,
  output logic                  edn_req_o,
  input  logic                  edn_ack_i,
  input  logic [SeedChunkW-1:0] edn_data_i,
  output logic                  prng_seed_en_o,
  output logic [255:0]          prng_seed_o,
  output logic                  prng_en_o,
  output logic [255:0]          prng_entropy_o,
  input  logic [OutputDw-1:0]   prng_data_i,
  input  logic                  prng_all_zero_i,
  output logic                  rnd_valid_o,
  input  logic                  rnd_ready_i,
  output logic [OutputDw-1:0]   rnd_data_o,
  output logic                  busy_o,
  output logic                  lockup_err_o
);

  localparam int unsigned NumChunks = 256 / SeedChunkW;
  localparam int unsigned ChunkCW   = NumChunks > 1 ? $clog2(NumChunks) : 1;
  localparam int unsigned StepW     = $clog2(ReseedInterval + 1);
  localparam int unsigned PtrW      = FifoDepth > 1 ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);

  typedef enum logic [1:0] {
    Idle,
    SeedReq,
    SeedLoad,
    Run
  } state_e;

  state_e              state_q;
  logic [ChunkCW-1:0]  chunk_q;
  logic [StepW-1:0]    step_q;
  logic [255:0]        seed_q;
  logic                lockup_q;
  logic [OutputDw-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]     rptr_q, wptr_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                run, empty, full, pop, push;
  logic                flush, byp, step_ok;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign run     = state_q == Run;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == CntW'(FifoDepth);
  assign pop     = ~empty & rnd_ready_i;
  assign step_ok = step_q < StepW'(ReseedInterval);

  assign prng_en_o = run & enable_i & ~prng_all_zero_i & ~reseed_req_i
                   & (~full | pop) & step_ok;

  // Flush never coincides with a step: every flush cause masks prng_en_o.
  assign flush = reseed_req_i | (run & (prng_all_zero_i | ~enable_i));

`ifdef PRIM_XOSHIRO_CTRL_BYPASS_EN
  assign byp         = empty & prng_en_o & rnd_ready_i;
  assign rnd_valid_o = ~empty | prng_en_o;
  assign rnd_data_o  = ~empty    ? mem_q[rptr_q] :
                       prng_en_o ? prng_data_i   : '0;
`else
  assign byp         = 1'b0;
  assign rnd_valid_o = ~empty;
  assign rnd_data_o  = mem_q[rptr_q];
`endif

  assign push = prng_en_o & ~byp;

  assign edn_req_o      = state_q == SeedReq;
  assign busy_o         = (state_q == SeedReq) | (state_q == SeedLoad);
  assign prng_seed_en_o = (state_q == SeedLoad) & (|seed_q);
  assign prng_seed_o    = seed_q;
  assign prng_entropy_o = '0;
  assign lockup_err_o   = lockup_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= Idle;
      chunk_q  <= '0;
      step_q   <= '0;
      seed_q   <= '0;
      lockup_q <= 1'b0;
    end else begin
      unique case (state_q)
        Idle: begin
          if (enable_i) state_q <= SeedReq;
        end
        SeedReq: begin
          if (edn_ack_i) begin
            seed_q[int'(chunk_q)*SeedChunkW +: SeedChunkW] <= edn_data_i;
            if (chunk_q == ChunkCW'(NumChunks - 1)) begin
              chunk_q <= '0;
              state_q <= SeedLoad;
            end else begin
              chunk_q <= chunk_q + 1'b1;
            end
          end
        end
        SeedLoad: begin
          // An all-zero seed would lock the PRNG; fetch a fresh one.
          if (seed_q == '0) begin
            chunk_q <= '0;
            state_q <= SeedReq;
          end else begin
            step_q  <= '0;
            state_q <= Run;
          end
        end
        Run: begin
          if (prng_en_o) step_q <= step_q + 1'b1;
          if (prng_all_zero_i) begin
            lockup_q <= 1'b1;
            state_q  <= SeedReq;
          end else if (reseed_req_i) begin
            state_q <= SeedReq;
          end else if (!enable_i) begin
            state_q <= Idle;
          end else if (!step_ok) begin
            state_q <= SeedReq;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      for (int unsigned i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        rptr_q <= '0;
        wptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wptr_q] <= prng_data_i;
          wptr_q        <= nxt(wptr_q);
        end
        if (pop) rptr_q <= nxt(rptr_q);
      end
    end
  end

endmodule

// File: tb/tb_prim_xoshiro256pp_ctrl.sv
// Self-checking bench for prim_xoshiro256pp_ctrl with a simple PRNG stand-in.
// Vector table for the first seed/run, hand sequences for reseed corners.
module tb_prim_xoshiro256pp_ctrl;

  localparam logic [63:0] K = 64'h9E3779B97F4A7C15;
  localparam logic [255:0] SEED1 =
    256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
  localparam logic [255:0] SEED2 =
    256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
  localparam logic [255:0] SEED3 =
    256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0;
  localparam logic [255:0] SEED5 =
    256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100;

  logic         clk = 1'b0;
  logic         rst_ni, enable_i, reseed_req_i, edn_ack_i;
  logic [31:0]  edn_data_i;
  logic         edn_req_o, prng_seed_en_o, prng_en_o;
  logic [255:0] prng_seed_o, prng_entropy_o;
  logic [63:0]  prng_data_i, rnd_data_o;
  logic         prng_all_zero_i, rnd_valid_o, rnd_ready_i;
  logic         busy_o, lockup_err_o;

  always #5 clk = ~clk;

  prim_xoshiro256pp_ctrl #(
    .OutputDw(64), .SeedChunkW(32),
    .ReseedInterval(4), .FifoDepth(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .enable_i(enable_i), .reseed_req_i(reseed_req_i),
    .edn_req_o(edn_req_o), .edn_ack_i(edn_ack_i),
    .edn_data_i(edn_data_i),
    .prng_seed_en_o(prng_seed_en_o), .prng_seed_o(prng_seed_o),
    .prng_en_o(prng_en_o), .prng_entropy_o(prng_entropy_o),
    .prng_data_i(prng_data_i), .prng_all_zero_i(prng_all_zero_i),
    .rnd_valid_o(rnd_valid_o), .rnd_ready_i(rnd_ready_i),
    .rnd_data_o(rnd_data_o), .busy_o(busy_o),
    .lockup_err_o(lockup_err_o)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] st;

  assign prng_data_i = st;

  // PRNG stand-in: loads the low seed word, advances by a constant per step.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) st <= '0;
    else if (prng_seed_en_o) st <= prng_seed_o[63:0];
    else if (prng_en_o) st <= st + K;
  end

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {edn_req_o, prng_seed_en_o, prng_en_o,
            rnd_valid_o, busy_o, lockup_err_o};
  endfunction

  // Scoreboard: words pushed when stepped, compared when consumed.
  always @(negedge clk) begin
    #2;
    if (rst_ni) begin
      if (prng_en_o || prng_seed_en_o) begin
        n_chk++;
        if (prng_en_o && prng_seed_en_o) begin
          n_fail++;
          $display("FAIL en_excl: seed_en and en both 1, required not both");
        end
      end
      if (prng_en_o) exp_q.push_back(st);
      if (rnd_valid_o && rnd_ready_i) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: got word %0h, required none", rnd_data_o);
        end else begin
          chk("sb_data", rnd_data_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic drv(input logic rst, en, rs, ack, input logic [31:0] d,
                     input logic rdy, az);
    @(negedge clk);
    rst_ni          = rst;
    enable_i        = en;
    reseed_req_i    = rs;
    edn_ack_i       = ack;
    edn_data_i      = d;
    rnd_ready_i     = rdy;
    prng_all_zero_i = az;
    #1;
  endtask

  task automatic step(input string nm, input logic rs, ack,
                      input logic [31:0] d, input logic rdy, az,
                      input logic [5:0] exp);
    drv(1'b1, 1'b1, rs, ack, d, rdy, az);
    chk(nm, outs(), exp);
  endtask

  typedef struct {
    logic        en;
    logic        ack;
    logic        rdy;
    logic [31:0] data;
    logic [5:0]  exp;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // exp = {req, seed_en, prng_en, valid, busy, lockup}
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'd0, 6'b000000};
    for (int k = 1; k <= 8; k++)
      tbl[k] = '{1'b1, 1'b1, 1'b0, 32'(k), 6'b100010};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'd0, 6'b010010};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'd0, 6'b001000};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'd0, 6'b001100};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'd0, 6'b000100};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'd0, 6'b000100};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 32'd0, 6'b001100};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 32'd0, 6'b001100};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 32'd0, 6'b000100};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 32'd0, 6'b100110};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 32'd0, 6'b100010};

    rst_ni = 1'b0; enable_i = 1'b0; reseed_req_i = 1'b0;
    edn_ack_i = 1'b0; edn_data_i = '0; rnd_ready_i = 1'b0;
    prng_all_zero_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", outs(), 6'b000000);
    chk("reset_seed", prng_seed_o, '0);
    chk("reset_data", rnd_data_o, '0);

    for (int i = 0; i < 19; i++) begin
      drv(1'b1, tbl[i].en, 1'b0, tbl[i].ack, tbl[i].data, tbl[i].rdy, 1'b0);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    chk("seed1", prng_seed_o, SEED1);

    // All-zero seed is discarded, then a nonzero one loads.
    for (int k = 0; k < 8; k++)
      step("zero_ack", 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 6'b100010);
    step("zero_load", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b000010);
    for (int k = 0; k < 8; k++)
      step("seed2_ack", 1'b0, 1'b1, 32'h11111111 * (k + 1),
           1'b0, 1'b0, 6'b100010);
    step("seed2_load", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b010010);
    chk("seed2", prng_seed_o, SEED2);

    // Lockup with two words buffered.
    step("fill0", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b001000);
    step("fill1", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b001100);
    step("lock_cyc", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 6'b000100);
    step("lock_after", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b100011);
    exp_q.delete();

    // Reseed request mid-interval flushes and refetches.
    for (int k = 0; k < 8; k++)
      step("seed3_ack", 1'b0, 1'b1, 32'hA0 + k, 1'b0, 1'b0, 6'b100011);
    step("seed3_load", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b010011);
    chk("seed3", prng_seed_o, SEED3);
    step("rs_step", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b001001);
    step("rs_cyc", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 6'b000101);
    step("rs_flush", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b100011);
    exp_q.delete();
    for (int k = 0; k < 8; k++)
      step("seed4_ack", 1'b0, 1'b1, 32'hB0 + k, 1'b0, 1'b0, 6'b100011);
    step("seed4_load", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b010011);

    // Full-rate run to the interval with the consumer always ready.
    step("run_c1", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 6'b001001);
    for (int k = 0; k < 3; k++)
      step("run_c2", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 6'b001101);
    step("run_c5", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 6'b000101);
    for (int k = 0; k < 3; k++)
      step("part_ack", 1'b0, 1'b1, 32'h200 + k, 1'b0, 1'b0, 6'b100011);

    // Reset after three acks; next seed needs eight fresh chunks.
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("rst_outs", outs(), 6'b000000);
    chk("rst_seed", prng_seed_o, '0);
    chk("rst_data", rnd_data_o, '0);
    exp_q.delete();
    step("rst_idle", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b000000);
    for (int k = 0; k < 8; k++)
      step("seed5_ack", 1'b0, 1'b1, 32'h100 + k, 1'b0, 1'b0, 6'b100010);
    step("seed5_load", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b010010);
    chk("seed5", prng_seed_o, SEED5);
    step("seed5_step", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 6'b001000);

    // Dropping enable in RUN flushes and returns to IDLE.
    drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("dis_cyc", outs(), 6'b000100);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("dis_idle", outs(), 6'b000000);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
